// File: rtl/uart_rx_ctrl.sv
// ============================================================================
// Module      : uart_rx_ctrl
// Description : Receive-side controller for the UART receiver. Captures each
//               completed byte into a FIFO, owns the parity configuration,
//               keeps sticky error/overrun/timeout status, raises a combined
//               level interrupt and exposes four 8-bit registers on a
//               single-cycle bus slave.
// Optional    : `define UART_RX_TIMEOUT_EN adds the idle-timeout counter,
//               STATUS[5] and CTRL[5] (ie_to). Undefined: both read 0.
// Ports       : clk, rst_n (async, active-low)
//               rx_data/rx_valid/rx_perr/rx_ferr - byte strobe from receiver
//               parity[1:0]                      - {enable, seed} to receiver
//               bus_sel/bus_we/bus_addr/bus_wdata/bus_rdata - register bus
//               irq                              - level interrupt
// Registers   : 0 DATA (R, pops) 1 STATUS (R, clears sticky bits)
//               2 CTRL (R/W, reset 0x04) 3 LEVEL (R)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_ctrl #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned AW          = 4,
    parameter int unsigned TIMEOUT_CYC = 320
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_perr,
    input  logic       rx_ferr,
    output logic [1:0] parity,
    input  logic       bus_sel,
    input  logic       bus_we,
    input  logic [1:0] bus_addr,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       irq
);

    localparam logic [1:0]  C_ADDR_DATA   = 2'd0;
    localparam logic [1:0]  C_ADDR_STATUS = 2'd1;
    localparam logic [1:0]  C_ADDR_CTRL   = 2'd2;
    localparam logic [1:0]  C_ADDR_LEVEL  = 2'd3;
    localparam logic [AW:0] C_DEPTH_CNT   = (AW+1)'(DEPTH);
    localparam logic [5:0]  C_CTRL_RST    = 6'h04;
`ifdef UART_RX_TIMEOUT_EN
    localparam logic [5:0]  C_CTRL_MASK   = 6'h3F;
`else
    localparam logic [5:0]  C_CTRL_MASK   = 6'h1F;
`endif

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          ovr_q,    ovr_d;
    logic          perr_q,   perr_d;
    logic          ferr_q,   ferr_d;
    logic          to_q,     to_d;
    logic [5:0]    ctrl_q,   ctrl_d;     // {ie_to, ie_err, ie_rx, rx_en, parity}
    logic [7:0]    rdata_q,  rdata_d;
    logic          irq_q,    irq_d;

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    logic          w_rd;
    logic          w_wr;
    logic          w_stat_rd;
    logic          w_nempty;
    logic          w_full;
    logic          w_pop;
    logic [AW:0]   w_cnt_pop;
    logic          w_full_after_pop;
    logic          w_cap;
    logic          w_push;
    logic          w_ovr_set;
    logic          w_to_set;
    logic          w_unused;

    assign w_rd      = bus_sel & ~bus_we;
    assign w_wr      = bus_sel &  bus_we;
    assign w_stat_rd = w_rd & (bus_addr == C_ADDR_STATUS);
    assign w_nempty  = (count_q != '0);
    assign w_full    = (count_q == C_DEPTH_CNT);
    assign w_pop     = w_rd & (bus_addr == C_ADDR_DATA) & w_nempty;

    // Fullness is judged after a same-cycle pop so a push into a full FIFO
    // that is being read is accepted rather than counted as an overrun.
    assign w_cnt_pop        = count_q - (AW+1)'(w_pop);
    assign w_full_after_pop = (w_cnt_pop == C_DEPTH_CNT);
    assign w_cap            = rx_valid & ctrl_q[2];
    assign w_push           = w_cap & ~w_full_after_pop;
    assign w_ovr_set        = w_cap &  w_full_after_pop;

    assign w_unused = ^bus_wdata[7:6];

    // ------------------------------------------------------------------------
    // Idle timeout
    // ------------------------------------------------------------------------
`ifdef UART_RX_TIMEOUT_EN
    localparam int unsigned           C_TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [C_TO_W-1:0]     C_TO_MAX = C_TO_W'(TIMEOUT_CYC);

    logic [C_TO_W-1:0] to_cnt_q, to_cnt_d;

    // Saturating counter: the flag is raised only on the step into the
    // saturation value, so it fires once per idle period.
    always_comb begin
        to_cnt_d = to_cnt_q;
        w_to_set = 1'b0;
        if (rx_valid || w_pop || !w_nempty) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != C_TO_MAX) begin
            to_cnt_d = to_cnt_q + C_TO_W'(1);
            w_to_set = (to_cnt_q == (C_TO_MAX - C_TO_W'(1)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign w_to_set = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q + AW'(w_pop);
        wr_ptr_d = wr_ptr_q + AW'(w_push);
        count_d  = w_cnt_pop + (AW+1)'(w_push);

        // Clear first, then set, so a set in the clearing cycle survives.
        ovr_d  = (ovr_q  & ~w_stat_rd) | w_ovr_set;
        perr_d = (perr_q & ~w_stat_rd) | (w_cap & rx_perr);
        ferr_d = (ferr_q & ~w_stat_rd) | (w_cap & rx_ferr);
        to_d   = (to_q   & ~w_stat_rd) | w_to_set;

        ctrl_d = ctrl_q;
        if (w_wr && (bus_addr == C_ADDR_CTRL)) begin
            ctrl_d = bus_wdata[5:0] & C_CTRL_MASK;
        end

        rdata_d = rdata_q;
        if (w_rd) begin
            case (bus_addr)
                C_ADDR_DATA:   rdata_d = w_nempty ? mem_q[rd_ptr_q] : 8'h00;
                C_ADDR_STATUS: rdata_d = {2'b00, to_q, ferr_q, perr_q, ovr_q,
                                          w_full, w_nempty};
                C_ADDR_CTRL:   rdata_d = {2'b00, ctrl_q};
                C_ADDR_LEVEL:  rdata_d = 8'(count_q);
                default:       rdata_d = 8'h00;
            endcase
        end

        irq_d = (ctrl_q[3] & w_nempty)
              | (ctrl_q[4] & (ovr_q | perr_q | ferr_q))
              | (ctrl_q[5] & to_q);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            to_q     <= 1'b0;
            ctrl_q   <= C_CTRL_RST;
            rdata_q  <= 8'h00;
            irq_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            to_q     <= to_d;
            ctrl_q   <= ctrl_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end

    // Storage array carries no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    assign parity    = ctrl_q[1:0];
    assign bus_rdata = rdata_q;
    assign irq       = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// ============================================================================
// Module      : tb_uart_rx_ctrl
// Description : Self-checking bench for uart_rx_ctrl. A queue-based reference
//               model predicts read data, irq and parity each cycle; directed
//               steps cover the documented scenarios, followed by a random
//               phase with a mid-run reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_ctrl;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int TO    = 320;
`ifdef UART_RX_TIMEOUT_EN
    localparam bit         C_TO_EN   = 1'b1;
    localparam logic [7:0] C_CTRL_MASK = 8'h3F;
`else
    localparam bit         C_TO_EN   = 1'b0;
    localparam logic [7:0] C_CTRL_MASK = 8'h1F;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_perr;
    logic       rx_ferr;
    logic [1:0] parity;
    logic       bus_sel;
    logic       bus_we;
    logic [1:0] bus_addr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       irq;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT_CYC(TO)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_perr   (rx_perr),
        .rx_ferr   (rx_ferr),
        .parity    (parity),
        .bus_sel   (bus_sel),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .irq       (irq)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // ------------------------------------------------------------------------
    // Reference model: a byte queue plus flag bits and the CTRL value.
    // ------------------------------------------------------------------------
    logic [7:0] m_q[$];
    bit         m_ovr, m_perr, m_ferr, m_to;
    logic [7:0] m_ctrl;
    logic [7:0] m_rdata;
    int         m_idle;

    function automatic void model_reset();
        m_q.delete();
        m_ovr = 0; m_perr = 0; m_ferr = 0; m_to = 0;
        m_ctrl = 8'h04; m_rdata = 8'h00; m_idle = 0;
    endfunction

    // One bus/receiver cycle: predict, drive, clock, check, advance model.
    task automatic cyc(input bit rxv, input logic [7:0] d, input bit pe, input bit fe,
                       input bit sel, input bit we, input logic [1:0] a,
                       input logic [7:0] wd, output logic [7:0] rd);
        bit         rdacc;
        bit         empty;
        bit         popped;
        bit         exp_irq;
        logic [7:0] exp_rd;
        rdacc  = sel && !we;
        empty  = (m_q.size() == 0);
        popped = 0;
        exp_rd = m_rdata;
        if (rdacc) begin
            case (a)
                2'd0: exp_rd = empty ? 8'h00 : m_q[0];
                2'd1: exp_rd = {2'b00, m_to, m_ferr, m_perr, m_ovr,
                                m_q.size() == DEPTH, !empty};
                2'd2: exp_rd = m_ctrl;
                default: exp_rd = 8'(m_q.size());
            endcase
        end
        exp_irq = (m_ctrl[3] && !empty) || (m_ctrl[4] && (m_ovr || m_perr || m_ferr))
                || (m_ctrl[5] && m_to);

        rx_valid = rxv; rx_data = d; rx_perr = pe; rx_ferr = fe;
        bus_sel = sel; bus_we = we; bus_addr = a; bus_wdata = wd;
        @(posedge clk);
        #1;

        if (rdacc && a == 2'd0 && !empty) begin
            void'(m_q.pop_front());
            popped = 1;
        end
        if (rdacc && a == 2'd1) begin
            m_ovr = 0; m_perr = 0; m_ferr = 0; m_to = 0;
        end
        if (rxv && m_ctrl[2]) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else                    m_ovr = 1;
            if (pe) m_perr = 1;
            if (fe) m_ferr = 1;
        end
        if (C_TO_EN) begin
            if (rxv || popped || empty) m_idle = 0;
            else if (m_idle < TO) begin
                m_idle++;
                if (m_idle == TO) m_to = 1;
            end
        end
        if (sel && we && a == 2'd2) m_ctrl = wd & C_CTRL_MASK;
        m_rdata = exp_rd;

        chk_eq("rdata",  bus_rdata, exp_rd);
        chk_eq("irq",    irq, exp_irq);
        chk_eq("parity", parity, m_ctrl[1:0]);
        rd = bus_rdata;
    endtask

    task automatic idle(input int n);
        logic [7:0] r;
        for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0, 0, 0, 2'd0, 8'h00, r);
    endtask

    task automatic push(input logic [7:0] d, input bit pe, input bit fe);
        logic [7:0] r;
        cyc(1, d, pe, fe, 0, 0, 2'd0, 8'h00, r);
    endtask

    task automatic rreg(input logic [1:0] a, output logic [7:0] r);
        cyc(0, 8'h00, 0, 0, 1, 0, a, 8'h00, r);
    endtask

    task automatic wreg(input logic [1:0] a, input logic [7:0] wd);
        logic [7:0] r;
        cyc(0, 8'h00, 0, 0, 1, 1, a, wd, r);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rx_valid = 0; rx_data = 0; rx_perr = 0; rx_ferr = 0;
        bus_sel = 0; bus_we = 0; bus_addr = 0; bus_wdata = 0;
        #2;
        chk_eq("rst_rdata",  bus_rdata, 8'h00);
        chk_eq("rst_irq",    irq, 1'b0);
        chk_eq("rst_parity", parity, 2'b00);
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] first;
        model_reset();
        do_reset();

        // Reset register values
        rreg(2'd2, r); chk_eq("ctrl_rst",   r, 8'h04);
        rreg(2'd1, r); chk_eq("status_rst", r, 8'h00);
        rreg(2'd3, r); chk_eq("level_rst",  r, 8'h00);

        // Two bytes in, two out, then an empty read
        push(8'h55, 0, 0);
        push(8'hA3, 0, 0);
        rreg(2'd3, r); chk_eq("level2", r, 8'd2);
        rreg(2'd0, r); chk_eq("data55", r, 8'h55);
        rreg(2'd3, r); chk_eq("level1", r, 8'd1);
        rreg(2'd0, r); chk_eq("dataA3", r, 8'hA3);
        rreg(2'd3, r); chk_eq("level0", r, 8'd0);
        rreg(2'd0, r); chk_eq("data_empty", r, 8'h00);
        rreg(2'd3, r); chk_eq("level0b", r, 8'd0);

        // Overflow by one
        for (int i = 0; i < 17; i++) push(8'(i + 8'h30), 0, 0);
        rreg(2'd3, r); chk_eq("level_full", r, 8'd16);
        rreg(2'd1, r); chk_eq("status_ovr", r, 8'h07);
        rreg(2'd1, r); chk_eq("status_clr", r, 8'h03);
        for (int i = 0; i < 16; i++) rreg(2'd0, r);
        chk_eq("drain_last", r, 8'h3F);

        // Error flags and irq
        wreg(2'd2, 8'h14);
        push(8'h10, 1, 1);
        chk_eq("irq_lag", irq, 1'b0);
        idle(1);
        chk_eq("irq_err", irq, 1'b1);
        rreg(2'd1, r); chk_eq("status_err", r, 8'h19);
        idle(1);
        chk_eq("irq_drop", irq, 1'b0);
        rreg(2'd0, r); chk_eq("data10", r, 8'h10);

        // Simultaneous push and pop on a full FIFO
        wreg(2'd2, 8'h04);
        for (int i = 0; i < 16; i++) push(8'(8'hC0 + i), 0, 0);
        cyc(1, 8'hEE, 0, 0, 1, 0, 2'd0, 8'h00, first);
        chk_eq("simul_head", first, 8'hC0);
        rreg(2'd3, r); chk_eq("simul_level", r, 8'd16);
        rreg(2'd1, r); chk_eq("simul_noovr", r, 8'h03);
        for (int i = 0; i < 16; i++) rreg(2'd0, r);
        chk_eq("simul_tail", r, 8'hEE);

        // Parity follows CTRL
        wreg(2'd2, 8'h03);
        chk_eq("parity11", parity, 2'b11);

        // Idle timeout
        wreg(2'd2, 8'h24);
        push(8'h77, 0, 0);
        idle(TO + 5);
        chk_eq("irq_to", irq, C_TO_EN);
        rreg(2'd1, r); chk_eq("status_to", r, C_TO_EN ? 8'h21 : 8'h01);
        idle(TO + 5);
        rreg(2'd1, r); chk_eq("to_once", r, 8'h01);
        rreg(2'd0, r); chk_eq("data77", r, 8'h77);

        // Random traffic with a mid-run reset
        for (int i = 0; i < 3000; i++) begin
            bit         rxv;
            bit         sel;
            bit         we;
            logic [7:0] wd;
            if (i == 1500) do_reset();
            rxv = ($urandom_range(0, 2) == 0);
            sel = ($urandom_range(0, 1) == 1);
            we  = ($urandom_range(0, 5) == 0);
            wd  = 8'($urandom);
            if ($urandom_range(0, 3) != 0) wd[2] = 1'b1;
            cyc(rxv, 8'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                sel, we, 2'($urandom), wd, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
